// File: rtl/ps2_scan_sequencer_if.sv
// Event/frame bundle between the PS/2 receiver, the sequencer and its consumer.
// The master drives frames, ready and clear; the slave returns events and status.
interface ps2_scan_sequencer_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             FRAME_VALID;
   logic [10:0]      FRAME_CODE;
   logic             EVT_READY;
   logic             CLR_STATUS;
   logic             EVT_VALID;
   logic [7:0]       EVT_CODE;
   logic             EVT_EXT;
   logic             EVT_BREAK;
   logic [LW-1:0]    FIFO_LEVEL;
   logic             OVERFLOW;
   logic             KBD_OK;
   logic             KBD_ERR;
   logic [CNT_W-1:0] ERR_CNT;

   modport master (
      output FRAME_VALID, FRAME_CODE, EVT_READY, CLR_STATUS,
      input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK,
      input  FIFO_LEVEL, OVERFLOW, KBD_OK, KBD_ERR, ERR_CNT
   );

   modport slave (
      input  FRAME_VALID, FRAME_CODE, EVT_READY, CLR_STATUS,
      output EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK,
      output FIFO_LEVEL, OVERFLOW, KBD_OK, KBD_ERR, ERR_CNT
   );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// PS/2 frame checker, E0/F0/E1 prefix sequencer and key-event FIFO.
// TYPEMATIC_FILTER_EN: suppress repeated makes of the held key.
module ps2_scan_sequencer #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 8
) (
   input  logic                CLK,
   input  logic                RST_N,
   ps2_scan_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_skip, w_skip_nxt;
   logic [TW-1:0]    r_tmo;
   logic             r_fv_q;
   logic             r_evt_vld;
   logic [9:0]       r_evt;
   logic [9:0]       r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [LW-1:0]    r_cnt;
   logic             r_ovf, r_ok, r_kerr;
   logic [CNT_W-1:0] r_err_cnt;

   logic       w_edge, w_good, w_frame, w_bad, w_tmo_hit;
   logic [7:0] w_d, w_code;
   logic       w_emit, w_ext, w_brk, w_set_ok, w_set_kerr;
   logic       w_push_evt, w_full, w_pop, w_push, w_vld;

   assign w_edge    = bus.FRAME_VALID & ~r_fv_q;
   assign w_d       = bus.FRAME_CODE[8:1];
   assign w_good    = ~bus.FRAME_CODE[0] & bus.FRAME_CODE[10]
                    & (^bus.FRAME_CODE[9:1]);
   assign w_frame   = w_edge & w_good;
   assign w_bad     = w_edge & ~w_good;
   assign w_tmo_hit = (r_state != S_IDLE) & ~w_edge & (r_tmo == TMO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip;
      w_emit      = 1'b0;
      w_code      = w_d;
      w_ext       = 1'b0;
      w_brk       = 1'b0;
      w_set_ok    = 1'b0;
      w_set_kerr  = 1'b0;
      if (w_bad || w_tmo_hit) begin
         w_state_nxt = S_IDLE;
      end else if (w_frame) begin
         unique case (r_state)
            S_IDLE: begin
               unique case (1'b1)
                  (w_d == 8'hE0): w_state_nxt = S_EXT;
                  (w_d == 8'hF0): w_state_nxt = S_BRK;
                  (w_d == 8'hE1): begin
                     w_state_nxt = S_PAUSE;
                     w_skip_nxt  = 3'd7;
                  end
                  (w_d == 8'hAA): w_set_ok   = 1'b1;
                  (w_d == 8'hFC): w_set_kerr = 1'b1;
                  default:        w_emit     = 1'b1;
               endcase
            end
            S_EXT: begin
               w_state_nxt = S_IDLE;
               unique case (1'b1)
                  (w_d == 8'hF0): w_state_nxt = S_EXT_BRK;
                  (w_d == 8'h12): begin end
                  default: begin
                     w_emit = 1'b1;
                     w_ext  = 1'b1;
                  end
               endcase
            end
            S_BRK: begin
               w_state_nxt = S_IDLE;
               w_emit      = 1'b1;
               w_brk       = 1'b1;
            end
            S_EXT_BRK: begin
               w_state_nxt = S_IDLE;
               w_emit      = (w_d != 8'h12);
               w_ext       = 1'b1;
               w_brk       = 1'b1;
            end
            S_PAUSE: begin
               if (r_skip == 3'd1) begin
                  w_state_nxt = S_IDLE;
                  w_emit      = 1'b1;
                  w_code      = 8'h77;
                  w_ext       = 1'b1;
               end else begin
                  w_skip_nxt = r_skip - 3'd1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef TYPEMATIC_FILTER_EN
   logic       r_held_vld;
   logic [8:0] r_held;
   logic       w_match;

   assign w_match    = r_held_vld & (r_held == {w_code, w_ext});
   assign w_push_evt = w_emit & ~(w_match & ~w_brk);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_held_vld <= 1'b0;
         r_held     <= '0;
      end else if (w_tmo_hit) begin
         r_held_vld <= 1'b0;
      end else if (w_emit && !w_brk) begin
         r_held_vld <= 1'b1;
         r_held     <= {w_code, w_ext};
      end else if (w_emit && w_match) begin
         r_held_vld <= 1'b0;
      end
   end
`else
   assign w_push_evt = w_emit;
`endif

   assign w_vld  = (r_cnt != '0);
   assign w_full = (r_cnt == FULL_LVL);
   assign w_pop  = w_vld & bus.EVT_READY;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = r_evt_vld & (~w_full | w_pop);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_fv_q    <= 1'b0;
         r_state   <= S_IDLE;
         r_skip    <= '0;
         r_tmo     <= '0;
         r_evt_vld <= 1'b0;
         r_evt     <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
      end else begin
         r_fv_q    <= bus.FRAME_VALID;
         r_state   <= w_state_nxt;
         r_skip    <= w_skip_nxt;
         r_evt_vld <= w_push_evt;
         if (w_push_evt) r_evt <= {w_code, w_ext, w_brk};
         if (r_state == S_IDLE || w_edge || w_tmo_hit) r_tmo <= '0;
         else r_tmo <= r_tmo + 1'b1;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wptr] <= r_evt;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ovf     <= 1'b0;
         r_ok      <= 1'b0;
         r_kerr    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (r_evt_vld && w_full && !w_pop) r_ovf <= 1'b1;
         else if (bus.CLR_STATUS)           r_ovf <= 1'b0;
         if (w_set_ok) r_ok <= 1'b1;
         if (w_set_kerr)          r_kerr <= 1'b1;
         else if (bus.CLR_STATUS) r_kerr <= 1'b0;
         if (w_bad) begin
            if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
         end else if (bus.CLR_STATUS) begin
            r_err_cnt <= '0;
         end
      end
   end

   assign bus.EVT_VALID  = w_vld;
   assign {bus.EVT_CODE, bus.EVT_EXT, bus.EVT_BREAK} =
      w_vld ? r_mem[r_rptr] : 10'd0;
   assign bus.FIFO_LEVEL = r_cnt;
   assign bus.OVERFLOW   = r_ovf;
   assign bus.KBD_OK     = r_ok;
   assign bus.KBD_ERR    = r_kerr;
   assign bus.ERR_CNT    = r_err_cnt;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: a behavioural decoder model
// queues expected events, a monitor pops them on each handshake.
module tb_ps2_scan_sequencer;
   localparam int DEPTH = 8;
   localparam int TMO   = 64;
   localparam int CNT_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ps2_scan_sequencer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   ps2_scan_sequencer #(
      .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .bus(bus.slave)
   );

   typedef enum {M_IDLE, M_EXT, M_BRK, M_XBRK, M_PAUSE} mst_t;

   int         n_chk = 0;
   int         n_fail = 0;
   int         n_pop = 0;
   logic [9:0] m_q[$];
   mst_t       m_st = M_IDLE;
   int         m_skip = 0;
   bit         m_nopop = 0;
   bit         m_ovf = 0;
   bit         m_hv = 0;
   logic [8:0] m_held = '0;
   int         p0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input bit bad);
      logic p;
      p = ~^d;
      if (bad) p = ~p;
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic emit(input logic [7:0] c, input bit x, input bit b);
`ifdef TYPEMATIC_FILTER_EN
      if (!b && m_hv && m_held == {c, x}) return;
      if (!b) begin
         m_hv   = 1;
         m_held = {c, x};
      end else if (m_hv && m_held == {c, x}) begin
         m_hv = 0;
      end
`endif
      if (m_nopop && m_q.size() >= DEPTH) m_ovf = 1;
      else m_q.push_back({c, x, b});
   endtask

   task automatic mdl(input logic [7:0] d, input bit bad);
      if (bad) begin
         m_st = M_IDLE;
         return;
      end
      case (m_st)
         M_IDLE:
            if (d == 8'hE0) m_st = M_EXT;
            else if (d == 8'hF0) m_st = M_BRK;
            else if (d == 8'hE1) begin
               m_st   = M_PAUSE;
               m_skip = 7;
            end else if (d != 8'hAA && d != 8'hFC) emit(d, 0, 0);
         M_EXT: begin
            m_st = M_IDLE;
            if (d == 8'hF0) m_st = M_XBRK;
            else if (d != 8'h12) emit(d, 1, 0);
         end
         M_BRK: begin
            m_st = M_IDLE;
            emit(d, 0, 1);
         end
         M_XBRK: begin
            m_st = M_IDLE;
            if (d != 8'h12) emit(d, 1, 1);
         end
         default: begin
            m_skip--;
            if (m_skip == 0) begin
               m_st = M_IDLE;
               emit(8'h77, 1, 0);
            end
         end
      endcase
   endtask

   task automatic send(input logic [7:0] d, input bit bad = 0);
      tick();
      bus.FRAME_CODE  = frame(d, bad);
      bus.FRAME_VALID = 1'b1;
      mdl(d, bad);
      repeat (3) tick();
      bus.FRAME_VALID = 1'b0;
      repeat (2) tick();
   endtask

   task automatic gap(input int n);
      repeat (n) tick();
      if (n >= TMO && m_st != M_IDLE) begin
         m_st = M_IDLE;
         m_hv = 0;
      end
   endtask

   task automatic drain();
      bus.EVT_READY = 1'b1;
      for (int i = 0; i < 64 && (m_q.size() != 0 || bus.EVT_VALID); i++)
         tick();
      check("drain_q", m_q.size(), 0);
      check("drain_lvl", bus.FIFO_LEVEL, 0);
   endtask

   task automatic pulse_clr();
      tick();
      bus.CLR_STATUS = 1'b1;
      tick();
      bus.CLR_STATUS = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.EVT_VALID && bus.EVT_READY) begin
         n_pop++;
         check("evt_expected", m_q.size() != 0, 1);
         if (m_q.size() != 0)
            check("evt", {bus.EVT_CODE, bus.EVT_EXT, bus.EVT_BREAK},
                  m_q.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.FRAME_VALID = 1'b0;
      bus.FRAME_CODE  = '0;
      bus.EVT_READY   = 1'b0;
      bus.CLR_STATUS  = 1'b0;
      repeat (3) tick();
      check("rst_outs", {bus.EVT_VALID, bus.EVT_CODE, bus.EVT_EXT,
            bus.EVT_BREAK, bus.FIFO_LEVEL, bus.OVERFLOW, bus.KBD_OK,
            bus.KBD_ERR, bus.ERR_CNT}, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // latency and hold with consumer stalled
      tick();
      bus.FRAME_CODE  = frame(8'h1C, 0);
      bus.FRAME_VALID = 1'b1;
      mdl(8'h1C, 0);
      tick();
      check("lat_n1_valid", bus.EVT_VALID, 0);
      tick();
      check("lat_n2_valid", bus.EVT_VALID, 1);
      check("lat_code", bus.EVT_CODE, 8'h1C);
      check("lat_flags", {bus.EVT_EXT, bus.EVT_BREAK}, 0);
      check("lat_level", bus.FIFO_LEVEL, 1);
      tick();
      check("hold_code", bus.EVT_CODE, 8'h1C);
      check("hold_level", bus.FIFO_LEVEL, 1);
      bus.FRAME_VALID = 1'b0;
      drain();

      // prefix sequences
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'h12);
      send(8'hE0); send(8'hF0); send(8'h12);
      send(8'h5A);
      drain();

      // framing errors
      send(8'h1C, 1);
      check("err_cnt1", bus.ERR_CNT, 1);
      send(8'h1C);
      send(8'hE0); send(8'h00, 1); send(8'h75);
      check("err_cnt2", bus.ERR_CNT, 2);
      drain();
      pulse_clr();
      check("err_clr", bus.ERR_CNT, 0);

      // self-test status
      send(8'hAA);
      check("kbd_ok", bus.KBD_OK, 1);
      send(8'hFC);
      check("kbd_err", bus.KBD_ERR, 1);
      pulse_clr();
      check("kbd_err_clr", bus.KBD_ERR, 0);
      drain();

      // prefix timeout
      send(8'hE0);
      gap(TMO + 5);
      send(8'h1C);
      send(8'hE0);
      gap(TMO - 20);
      send(8'h75);
      drain();

      // pause sequence
      p0 = n_pop;
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      drain();
      check("pause_cnt", n_pop - p0, 1);

      // typematic repeats
      p0 = n_pop;
      send(8'h2A); send(8'h2A); send(8'h2A); send(8'hF0); send(8'h2A);
      drain();
`ifdef TYPEMATIC_FILTER_EN
      check("typematic_cnt", n_pop - p0, 2);
`else
      check("typematic_cnt", n_pop - p0, 4);
`endif

      // overflow
      bus.EVT_READY = 1'b0;
      m_nopop = 1;
      m_ovf = 0;
      for (int i = 0; i < 9; i++) send(8'h40 + 8'(i));
      check("full_level", bus.FIFO_LEVEL, DEPTH);
      check("ovf_set", bus.OVERFLOW, m_ovf);
      m_nopop = 0;
      pulse_clr();
      check("ovf_clr", bus.OVERFLOW, 0);
      tick();
      bus.FRAME_CODE  = frame(8'h30, 0);
      bus.FRAME_VALID = 1'b1;
      mdl(8'h30, 0);
      tick();
      bus.EVT_READY = 1'b1;
      tick();
      bus.EVT_READY = 1'b0;
      check("full_pp_level", bus.FIFO_LEVEL, DEPTH);
      check("full_pp_ovf", bus.OVERFLOW, 0);
      bus.FRAME_VALID = 1'b0;
      tick();
      drain();

      // reset mid-sequence
      bus.EVT_READY = 1'b0;
      send(8'h1C); send(8'hAA); send(8'hE0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {bus.EVT_VALID, bus.EVT_CODE, bus.EVT_EXT,
            bus.EVT_BREAK, bus.FIFO_LEVEL, bus.OVERFLOW, bus.KBD_OK,
            bus.KBD_ERR, bus.ERR_CNT}, 0);
      m_q.delete();
      m_st = M_IDLE;
      m_hv = 0;
      tick();
      rst_n = 1'b1;
      bus.EVT_READY = 1'b1;
      send(8'h1C);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
- Consumes raw 11-bit PS/2 frames from the keyboard receiver (frame-done strobe plus frame word).
- Validates framing and parity, and tracks E0/F0/E1 prefix sequences in an FSM.
- Emits one decoded key event per make/break: code, extended flag, break flag.
- Buffers events in a FIFO drained with a valid/ready handshake by the display/LED logic or a CPU.

Parameters:
- DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, CLK cycles a pending prefix may wait for its next byte before the FSM abandons it.
- CNT_W, 8, width of the parity/framing error counter; saturating.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- FRAME_VALID  in  1  high when the receiver has finished a frame; may stay high for several cycles.
- FRAME_CODE  in  11  bit0 start, bits8:1 data LSB-first, bit9 parity, bit10 stop.
- EVT_READY  in  1  consumer accepts the head event.
- CLR_STATUS  in  1  one-cycle pulse that clears OVERFLOW, KBD_ERR and ERR_CNT.
- EVT_VALID  out  1  FIFO not empty.
- EVT_CODE  out  8  head event scan code.
- EVT_EXT  out  1  head event was E0-prefixed.
- EVT_BREAK  out  1  head event is a release.
- FIFO_LEVEL  out  $clog2(DEPTH)+1  entries held.
- OVERFLOW  out  1  sticky; an event was dropped because the FIFO was full.
- KBD_OK  out  1  sticky; 0xAA self-test pass received.
- KBD_ERR  out  1  sticky; 0xFC self-test fail received.
- ERR_CNT  out  CNT_W  count of bad frames.

Behaviour:
- Reset: async on RST_N low. All outputs 0, FIFO empty, FSM in IDLE, timeout counter 0, FRAME_VALID edge register 0.
- Frame strobe: FRAME_VALID is edge-detected internally. Only a 0->1 transition counts; a level held for many cycles is one frame.
- Frame check: good when FRAME_CODE[0]=0, FRAME_CODE[10]=1, and XOR of bits9:1 = 1 (odd parity).
  - Bad frame: ERR_CNT increments (saturates at all-ones), FSM returns to IDLE, no event.
- Latency: edge detected in cycle N, FSM/event register updated at the end of N, FIFO written at the end of N+1, EVT_VALID high in N+2 when the FIFO was empty.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. d = data byte.
  - IDLE:
    - d=E0 -> EXT.
    - d=F0 -> BRK.
    - d=E1 -> PAUSE (skip counter=7).
    - d=AA -> set KBD_OK, stay.
    - d=FC -> set KBD_ERR, stay.
    - any other d -> emit {d, ext=0, brk=0}.
  - EXT:
    - d=F0 -> EXT_BRK.
    - d=12 (fake shift) -> IDLE, no event.
    - else emit {d, 1, 0} -> IDLE.
  - BRK: emit {d, 0, 1} -> IDLE.
  - EXT_BRK:
    - d=12 -> IDLE, no event.
    - else emit {d, 1, 1} -> IDLE.
  - PAUSE: decrement the counter per good frame. On the 7th frame emit {0x77, 1, 0} -> IDLE.
  - E0/F0 received inside BRK/EXT_BRK: treated as a data byte per the rules above; no nesting.
- Timeout: in any non-IDLE state the counter increments every CLK. Reaching TIMEOUT_CYCLES -> IDLE, no event. The counter clears on each accepted frame and in IDLE.
- FIFO handshake:
  - Pop when EVT_VALID & EVT_READY.
  - Push of an event when full -> event dropped, OVERFLOW set.
  - Simultaneous push and pop when full -> both occur, no overflow.
  - No bypass: a push into an empty FIFO appears on the outputs the next cycle.
  - Pointers wrap modulo DEPTH.
  - EVT_* are held stable while EVT_VALID & !EVT_READY.
- CLR_STATUS: clears the sticky flags and ERR_CNT.
  - Same-cycle set and clear: the set wins.
  - The FIFO and the FSM are unaffected.
- Reset asserted mid-sequence or mid-FIFO: all state is discarded immediately.

Optional Feature:
- TYPEMATIC_FILTER_EN defined:
  - A register holds the last make {code, ext} plus a held flag.
  - A make matching the held key is suppressed (no push).
  - A break of the held key clears the flag.
  - A make of a different key replaces the held key.
  - Timeout and reset clear the flag.
- Undefined: every make is pushed, including typematic repeats.

Test Plan:
- Good frame d=0x1C, no prefix -> EVT_VALID 2 cycles after the edge, EVT_CODE=1C, EXT=0, BREAK=0, FIFO_LEVEL=1.
- Sequence E0,F0,75 -> single event {75,1,1}. Sequence F0,1C -> {1C,0,1}. Sequence E0,12 -> no event.
- Frame 0x1C with the parity bit flipped -> no event, ERR_CNT=1. A following 0x1C decodes normally.
- Push 9 events with EVT_READY=0 (DEPTH=8) -> FIFO_LEVEL=8, OVERFLOW=1, first 8 codes pop in order.
  - Then hold EVT_READY=1 during a push while full -> level stays 8, no new overflow.
- E0 followed by an idle gap of TIMEOUT_CYCLES, then 0x1C -> {1C,0,0}. E1 plus 7 bytes -> one {77,1,0}.
- With TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C -> two events, make then break. Without the macro: four events. RST_N low mid-E0 -> all outputs 0.
